// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one tagged memory port between dcache (0), icache (1) and prefetcher (2).
// Fixed priority by default; define MEM_BUS_ARB_RR_EN for round-robin arbitration in IDLE.
`ifndef XLEN
`define XLEN 32
`endif

module mem_bus_arbiter #(
   parameter int unsigned NUM_REQ     = 3,
   parameter int unsigned NUM_TAGS    = 15,
   parameter int unsigned PF_MAX_OUTS = 4,
   parameter int unsigned ADDR_W      = `XLEN
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0][1:0]        req_command,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ-1:0][63:0]       req_data,
   input  logic [NUM_REQ-1:0][1:0]        req_size,
   output logic [NUM_REQ-1:0][3:0]        req_response,
   output logic [NUM_REQ-1:0][3:0]        req_tag,
   output logic [63:0]                    req_data_out,
   output logic [1:0]                     proc2mem_command,
   output logic [ADDR_W-1:0]              proc2mem_addr,
   output logic [63:0]                    proc2mem_data,
   output logic [1:0]                     proc2mem_size,
   input  logic [3:0]                     mem2proc_response,
   input  logic [63:0]                    mem2proc_data,
   input  logic [3:0]                     mem2proc_tag,
   output logic [2:0]                     pf_outstanding,
   output logic                           err_orphan,
   output logic                           err_dup_tag
);
   localparam int unsigned ID_W    = 2;
   localparam int unsigned NUM_ENT = NUM_TAGS + 1;
   localparam int unsigned PF_ID   = NUM_REQ - 1;
   localparam logic [1:0]  CMD_NONE = 2'd0;
   localparam logic [1:0]  CMD_LOAD = 2'd1;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   hold_id_q, hold_id_d;
   logic [NUM_REQ-1:0] eligible;
   logic              pick_valid, grant_valid;
   logic [ID_W-1:0]   pick_id, grant_id;
   logic              own_valid_q [NUM_ENT];
   logic [ID_W-1:0]   own_id_q    [NUM_ENT];
   logic [2:0]        pf_cnt_q;
   logic              err_orphan_q, err_dup_q;
   logic              accept, accept_load, resp_in_range;
   logic              ret_valid, ret_hit, pf_inc, pf_dec;
   logic [ID_W-1:0]   ret_owner;

`ifdef MEM_BUS_ARB_RR_EN
   logic [ID_W-1:0]   rr_ptr_q;
   logic [ID_W-1:0]   cand;
`endif

   // Eligibility and IDLE-state pick
   always_comb begin
      eligible   = '0;
      pick_valid = 1'b0;
      pick_id    = '0;
      for (int i = 0; i < NUM_REQ; i++) eligible[i] = (req_command[i] != CMD_NONE);
      if (32'(pf_cnt_q) >= PF_MAX_OUTS) eligible[PF_ID] = 1'b0;
`ifdef MEM_BUS_ARB_RR_EN
      cand = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
         if (!pick_valid && eligible[cand]) begin
            pick_valid = 1'b1;
            pick_id    = cand;
         end
      end
`else
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            pick_valid = 1'b1;
            pick_id    = ID_W'(i);
         end
      end
`endif
   end

   // Next-state and grant; a rejected grant is held without preemption until accepted or withdrawn
   always_comb begin
      state_d     = state_q;
      hold_id_d   = hold_id_q;
      grant_valid = 1'b0;
      grant_id    = '0;
      case (state_q)
         IDLE: begin
            grant_valid = pick_valid;
            grant_id    = pick_id;
            if (pick_valid && mem2proc_response == 4'd0) begin
               state_d   = HOLD;
               hold_id_d = pick_id;
            end
         end
         HOLD: begin
            grant_id = hold_id_q;
            if (req_command[hold_id_q] == CMD_NONE) begin
               state_d = IDLE;
            end else begin
               grant_valid = 1'b1;
               if (mem2proc_response != 4'd0) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (rst) grant_valid = 1'b0;
   end

   // Memory port and response/tag routing
   always_comb begin
      proc2mem_command = CMD_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      proc2mem_size    = '0;
      req_response     = '0;
      req_tag          = '0;
      if (grant_valid) begin
         proc2mem_command       = req_command[grant_id];
         proc2mem_addr          = req_addr[grant_id];
         proc2mem_data          = req_data[grant_id];
         proc2mem_size          = req_size[grant_id];
         req_response[grant_id] = mem2proc_response;
      end
      accept        = grant_valid && (mem2proc_response != 4'd0);
      accept_load   = accept && (proc2mem_command == CMD_LOAD);
      resp_in_range = (32'(mem2proc_response) <= NUM_TAGS);
      ret_valid     = !rst && (mem2proc_tag != 4'd0) && (32'(mem2proc_tag) <= NUM_TAGS);
      ret_hit       = ret_valid && own_valid_q[mem2proc_tag];
      ret_owner     = own_id_q[mem2proc_tag];
      for (int i = 0; i < NUM_REQ; i++)
         if (ret_hit && ret_owner == ID_W'(i)) req_tag[i] = mem2proc_tag;
      req_data_out  = rst ? 64'd0 : mem2proc_data;
      pf_inc        = accept_load && (grant_id == ID_W'(PF_ID));
      pf_dec        = ret_hit && (ret_owner == ID_W'(PF_ID));
   end

   // State, owner table, prefetch counter and sticky errors; retire is applied before record
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         hold_id_q    <= '0;
         pf_cnt_q     <= '0;
         err_orphan_q <= 1'b0;
         err_dup_q    <= 1'b0;
         own_valid_q  <= '{default: 1'b0};
         own_id_q     <= '{default: '0};
      end else begin
         state_q   <= state_d;
         hold_id_q <= hold_id_d;
         if (ret_hit) own_valid_q[mem2proc_tag] <= 1'b0;
         if ((mem2proc_tag != 4'd0) && !ret_hit) err_orphan_q <= 1'b1;
         if (accept_load && resp_in_range) begin
            own_valid_q[mem2proc_response] <= 1'b1;
            own_id_q[mem2proc_response]    <= grant_id;
            if (own_valid_q[mem2proc_response] && !(ret_hit && mem2proc_tag == mem2proc_response))
               err_dup_q <= 1'b1;
         end
         if (pf_inc && !pf_dec && pf_cnt_q != 3'd7)      pf_cnt_q <= pf_cnt_q + 3'd1;
         else if (pf_dec && !pf_inc && pf_cnt_q != 3'd0) pf_cnt_q <= pf_cnt_q - 3'd1;
      end
   end

`ifdef MEM_BUS_ARB_RR_EN
   // Round-robin pointer advances past each accepted grant
   always_ff @(posedge clk) begin
      if (rst)         rr_ptr_q <= '0;
      else if (accept) rr_ptr_q <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
   end
`endif

   assign pf_outstanding = pf_cnt_q;
   assign err_orphan     = err_orphan_q;
   assign err_dup_tag    = err_dup_q;

endmodule
